// File: rtl/bar_rr_arbiter.sv
// bar_rr_arbiter: round-robin arbiter sharing one 'bar' channel (data/valid/ready)
// between N_REQ producers. A grant lasts up to MAX_BURST handshakes, ends early if
// the owner drops valid, and every release is followed by one IDLE bubble cycle.
// Only the arbitration state is registered; the datapath is a combinational mux.
module bar_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*DATA_W-1:0]    in_data,
  input  logic [N_REQ-1:0]           in_valid,
  output logic [N_REQ-1:0]           in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gid;
  logic [CW-1:0]   beat_cnt;

  logic            found;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  next_ptr;
  logic            owner_valid;
  logic            hs;
  logic            last_beat;
  int              idx;

  // Round-robin search: first requester with valid, starting at ptr and wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found   = 1'b0;
    pick_id = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && in_valid[idx]) begin
        found   = 1'b1;
        pick_id = IDW'(idx);
      end
    end
  end

  // Owner-relative handshake decode and the pointer the releasing owner leaves behind.
  always_comb begin
    owner_valid = (state == GRANT) && in_valid[gid];
    hs          = owner_valid && out_ready;
    last_beat   = (beat_cnt == CW'(MAX_BURST - 1));
    if (gid == IDW'(N_REQ - 1)) next_ptr = '0;
    else                        next_ptr = gid + 1'b1;
  end

  // Pass-through mux while granted; all outputs forced to zero in IDLE (and thus in reset).
  always_comb begin
    in_ready    = '0;
    out_data    = '0;
    out_valid   = 1'b0;
    grant_valid = 1'b0;
    if (state == GRANT) begin
      grant_valid   = 1'b1;
      out_valid     = in_valid[gid];
      in_ready[gid] = out_ready;
      if (in_valid[gid]) out_data = in_data[int'(gid)*DATA_W +: DATA_W];
    end
  end

  assign grant_id = gid;

  // Arbitration FSM: pick an owner in IDLE, count beats and release in GRANT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gid      <= '0;
      beat_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (found) begin
            gid      <= pick_id;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!in_valid[gid]) begin
            state <= IDLE;
            ptr   <= next_ptr;
          end else if (hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              state <= IDLE;
              ptr   <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
